// File: rtl/lza_norm_sched.sv
// Two-requester round-robin front end sharing one LZA and one left shifter to normalize a-b.
// Optional arbitration stall counter: define LZA_NORM_SCHED_STALL_CNT_EN.

module lza37 #(
  parameter int W = 37
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [5:0]   lza_num_o,
  output logic         correct_sel_o
);
  logic [W-1:0] t_w;
  logic [W-1:0] z_sh;
  logic [W-1:0] e_sh;
  logic [W-1:0] f_w;

  // One-sided indicator (a >= b): the predicted leading one is the top differing bit whose
  // lower neighbour is not a borrow (a=0,b=1); it is exact or one position too high.
  always_comb begin
    t_w           = a_i ^ b_i;
    z_sh          = {~a_i[W-2:0] & b_i[W-2:0], 1'b0};
    e_sh          = {~t_w[W-2:0], 1'b0};
    f_w           = t_w & ~z_sh;
    lza_num_o     = '0;
    correct_sel_o = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (f_w[i]) begin
        lza_num_o     = 6'(W - 1 - i);
        correct_sel_o = e_sh[i];
      end
    end
  end
endmodule

module lshift37 #(
  parameter int W = 37
) (
  input  logic [W-1:0] data_i,
  input  logic [5:0]   shamt_i,
  output logic [W-1:0] data_o
);
  assign data_o = data_i << shamt_i;
endmodule

module lza_norm_sched #(
  parameter int LZA_WIDTH = 37
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [1:0]           i_req_valid,
  output logic [1:0]           o_req_ready,
  input  logic [LZA_WIDTH-1:0] i_op_a0,
  input  logic [LZA_WIDTH-1:0] i_op_b0,
  input  logic [LZA_WIDTH-1:0] i_op_a1,
  input  logic [LZA_WIDTH-1:0] i_op_b1,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [LZA_WIDTH-1:0] o_mant,
  output logic [5:0]           o_shamt,
  output logic                 o_zero,
  output logic                 o_id,
  output logic [15:0]          o_stall_cnt
);
  typedef enum logic [2:0] {IDLE, CALC, SHIFT, CORR, OUT} state_t;

  state_t               state_q, state_d;
  logic                 ptr_q, ptr_d;
  logic                 id_q, id_d;
  logic [LZA_WIDTH-1:0] a_q, a_d;
  logic [LZA_WIDTH-1:0] b_q, b_d;
  logic [LZA_WIDTH-1:0] diff_q, diff_d;
  logic [5:0]           lza_q, lza_d;
  logic [LZA_WIDTH-1:0] mant_q, mant_d;
  logic [5:0]           shamt_q, shamt_d;
  logic                 zero_q, zero_d;

  logic [1:0]           grant;
  logic                 hs;
  logic [5:0]           lza_num;
  logic                 unused_correct_sel;
  logic [LZA_WIDTH-1:0] sh_in;
  logic [5:0]           sh_amt;
  logic [LZA_WIDTH-1:0] sh_out;

  lza37 #(.W(LZA_WIDTH)) u_lza (
    .a_i           (a_q),
    .b_i           (b_q),
    .lza_num_o     (lza_num),
    .correct_sel_o (unused_correct_sel)
  );

  lshift37 #(.W(LZA_WIDTH)) u_shift (
    .data_i  (sh_in),
    .shamt_i (sh_amt),
    .data_o  (sh_out)
  );

  always_comb begin
    grant = 2'b00;
    if (state_q == IDLE && !i_rst) begin
      if (i_req_valid == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
      else                      grant = i_req_valid;
    end
  end

  assign o_req_ready = grant;
  assign hs          = |(i_req_valid & grant);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    lza_d   = lza_q;
    mant_d  = mant_q;
    shamt_d = shamt_q;
    zero_d  = zero_q;
    sh_in   = diff_q;
    sh_amt  = lza_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          id_d    = grant[1];
          a_d     = grant[1] ? i_op_a1 : i_op_a0;
          b_d     = grant[1] ? i_op_b1 : i_op_b0;
          ptr_d   = ~grant[1];
          state_d = CALC;
        end
      end
      CALC: begin
        diff_d = a_q - b_q;
        lza_d  = lza_num;
        if (a_q == b_q) begin
          zero_d  = 1'b1;
          mant_d  = '0;
          shamt_d = '0;
          state_d = OUT;
        end else begin
          zero_d  = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        mant_d  = sh_out;
        shamt_d = lza_q;
        state_d = sh_out[LZA_WIDTH-1] ? OUT : CORR;
      end
      // The LZA overshoots by at most one position, so a single extra shift always normalizes.
      CORR: begin
        sh_in   = mant_q;
        sh_amt  = 6'd1;
        mant_d  = sh_out;
        shamt_d = shamt_q + 6'd1;
        state_d = OUT;
      end
      OUT: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      lza_q   <= '0;
      mant_q  <= '0;
      shamt_q <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      lza_q   <= lza_d;
      mant_q  <= mant_d;
      shamt_q <= shamt_d;
      zero_q  <= zero_d;
    end
  end

  assign o_valid = (state_q == OUT) && !i_rst;
  assign o_mant  = mant_q;
  assign o_shamt = shamt_q;
  assign o_zero  = zero_q;
  assign o_id    = id_q;

`ifdef LZA_NORM_SCHED_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (|i_req_valid && !hs && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign o_stall_cnt = stall_q;
`else
  assign o_stall_cnt = 16'd0;
`endif

  a_ready_onehot: assert property (@(posedge i_clk) disable iff (i_rst) $onehot0(o_req_ready));
  a_shamt_range:  assert property (@(posedge i_clk) disable iff (i_rst)
                    o_valid |-> (o_shamt <= 6'(LZA_WIDTH - 1)));
  a_normalized:   assert property (@(posedge i_clk) disable iff (i_rst)
                    (o_valid && !o_zero) |-> o_mant[LZA_WIDTH-1]);
  a_hold_stable:  assert property (@(posedge i_clk) disable iff (i_rst)
                    (o_valid && !i_ready) |=> (o_valid && $stable({o_mant, o_shamt, o_zero, o_id})));
endmodule

// File: doc/lza_norm_sched.md
LZA_NORM_SCHED -- requirements
Module: lza_norm_sched

Interface
REQ-001 SHALL have parameter: LZA_WIDTH, 37, mantissa/LZA datapath width.
REQ-002 SHALL have port: i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: i_rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: i_req_valid  input  2  per-requester request valid (bit n = requester n).
REQ-005 SHALL have port: o_req_ready  output  2  per-requester accept; at most one bit high.
REQ-006 SHALL have ports: i_op_a0, i_op_b0, i_op_a1, i_op_b1  input  LZA_WIDTH each  magnitudes to subtract (a >= b guaranteed by requester).
REQ-007 SHALL have port: o_valid  output  1  result valid.
REQ-008 SHALL have port: i_ready  input  1  consumer accepts result.
REQ-009 SHALL have ports: o_mant  output  LZA_WIDTH  normalized a-b; o_shamt  output  6  total left shift; o_zero  output  1  a-b == 0; o_id  output  1  requester index.
REQ-010 SHALL have port: o_stall_cnt  output  16  arbitration stall counter (see Configuration).

Function
REQ-011 SHALL instantiate one lza37 and one lzd-free left shifter, shared by both requesters.
REQ-012 SHALL implement FSM states IDLE, CALC, SHIFT, CORR, OUT.
REQ-013 IDLE: o_req_ready high only for the granted requester; handshake = valid & ready; on handshake latch a, b, id, go CALC.
REQ-014 Arbitration round-robin: pointer ptr; both valid -> grant requester ptr; one valid -> grant it; after each grant ptr = ~granted id.
REQ-015 CALC: register diff = a-b (LZA_WIDTH bits), drive lza37 with latched a, b, register lza_num; diff == 0 -> go OUT with o_zero=1, o_mant=0, o_shamt=0; else go SHIFT.
REQ-016 SHIFT: mant = diff << lza_num, shamt = lza_num; mant[LZA_WIDTH-1]==1 -> OUT, else CORR.
REQ-017 CORR: mant = mant << 1, shamt = shamt + 1, go OUT (exactly one correction, LZA error bounded to 1).
REQ-018 OUT: o_valid high, outputs stable until i_ready; on o_valid & i_ready go IDLE, o_valid low next cycle.
REQ-019 Latency handshake->o_valid: 3 cycles normal, 4 with correction, 2 for zero result.
REQ-020 No new request accepted outside IDLE; o_req_ready = 0 in CALC..OUT and during reset.
REQ-021 o_shamt never exceeds LZA_WIDTH-1; nonzero result always has o_mant[LZA_WIDTH-1]=1.
REQ-022 lza37 correct_sel output unused by control; correction decided solely by REQ-016.

Reset
REQ-023 i_rst high: state=IDLE, ptr=0, o_valid=0, o_req_ready=0, o_mant=0, o_shamt=0, o_zero=0, o_id=0, o_stall_cnt=0.
REQ-024 Reset mid-operation discards in-flight transaction; no o_valid produced for it.
REQ-025 First cycle after reset release: IDLE, requester 0 has priority.

Configuration
REQ-026 Macro LZA_NORM_SCHED_STALL_CNT_EN defined: o_stall_cnt increments (saturating at 16'hFFFF) each cycle some i_req_valid bit is high and no handshake occurs; cleared only by reset.
REQ-027 Macro undefined: counter logic absent, o_stall_cnt tied to 0.

Verification
REQ-028 Req0 a=37'h0_0000_0100, b=37'h0_0000_0001 -> o_mant=37'h1F_E000_0000, o_shamt=29, o_zero=0, o_id=0, o_valid 3 or 4 cycles after handshake.
REQ-029 Req1 a=37'h10_0000_0000, b=0 -> o_mant=37'h10_0000_0000, o_shamt=0, o_id=1, latency 3.
REQ-030 a=b=37'h05_5555_5555 -> o_zero=1, o_mant=0, o_shamt=0, latency 2.
REQ-031 Both requesters valid continuously after reset -> grants alternate 0,1,0,1; held i_ready=0 for 5 cycles in OUT keeps outputs stable, no new grant.
REQ-032 Assert i_rst in SHIFT state -> next cycle o_valid=0, state IDLE, ptr=0, no result emitted.
REQ-033 With LZA_NORM_SCHED_STALL_CNT_EN, requester 1 valid during 3-cycle busy window -> o_stall_cnt=3 (+ cycles in OUT until i_ready); without macro o_stall_cnt=0.
